// File: rtl/mem_pkg.sv
// Shared types for the data-memory access unit: access sizes, FSM states
// and the decoded memory-operation descriptor handed over by execute.
package mem_pkg;

  typedef enum logic [1:0] {
    ACCESS_BYTE = 2'd0,
    ACCESS_HALF = 2'd1,
    ACCESS_WORD = 2'd2
  } access_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic         op;            // 1 = read, 0 = write
    access_size_t access_size;   // 2'b11 is reserved and always faults
    logic         read_unsigned; // zero-extend sub-word loads
  } mem_params_t;

  localparam logic OP_READ  = 1'b1;
  localparam logic OP_WRITE = 1'b0;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the data-memory bus.
// Store side: builds byte enables and lane-replicated write data.
// Load side: picks the addressed lane out of the bus word and extends it.
// Offsets below natural alignment are ignored here (half uses offset[1],
// word always uses lane 0); the top decides whether such accesses fault.
module mem_lane_align
  import mem_pkg::*;
(
  input  access_size_t size_i,
  input  logic [1:0]   offset_i,
  input  logic [31:0]  wdata_i,
  output logic [3:0]   be_o,
  output logic [31:0]  wdata_o,
  input  logic [31:0]  rdata_i,
  input  logic         unsigned_i,
  output logic [31:0]  rdata_o
);

  logic [1:0]  eff_off;
  logic [31:0] shifted;

  function automatic logic [31:0] ext8(input logic [7:0] v, input logic uns);
    return uns ? {24'b0, v} : {{24{v[7]}}, v};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] v, input logic uns);
    return uns ? {16'b0, v} : {{16{v[15]}}, v};
  endfunction

  // Lane selection, byte enables, store replication and load extension
  always_comb begin
    eff_off = 2'd0;
    be_o    = 4'hF;
    wdata_o = wdata_i;
    rdata_o = rdata_i;
    unique case (size_i)
      ACCESS_BYTE: begin
        eff_off = offset_i;
        be_o    = 4'b0001 << offset_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      ACCESS_HALF: begin
        eff_off = {offset_i[1], 1'b0};
        be_o    = 4'b0011 << {offset_i[1], 1'b0};
        wdata_o = {2{wdata_i[15:0]}};
      end
      default: begin
        eff_off = 2'd0;
        be_o    = 4'hF;
        wdata_o = wdata_i;
      end
    endcase
    shifted = rdata_i >> {eff_off, 3'b000};
    unique case (size_i)
      ACCESS_BYTE: rdata_o = ext8(shifted[7:0], unsigned_i);
      ACCESS_HALF: rdata_o = ext16(shifted[15:0], unsigned_i);
      default:     rdata_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory access unit: accepts one decoded load/store from execute,
// runs a req/ack bus transaction with a timeout, and returns a single
// response pulse carrying the extended load data or an error flag.
// Optional feature: define MEM_MISALIGN_TRAP_EN to fault misaligned
// half/word accesses instead of silently aligning them down.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  mem_params_t mem_params,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);

  mem_state_t  state_q;
  mem_params_t params_q;
  logic [1:0]  off_q;
  logic [31:0] wdata_q;
  logic [15:0] tmo_q;
  logic [15:0] tmo_d;
  logic        req_ready_q;
  logic        resp_valid_q;
  logic        resp_error_q;
  logic [31:0] resp_rdata_q;
  logic        bus_req_q;
  logic        bus_we_q;
  logic [31:0] bus_addr_q;

  logic        illegal_req;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;

  assign tmo_d = tmo_q + 16'd1;

  mem_lane_align u_align (
    .size_i     (params_q.access_size),
    .offset_i   (off_q),
    .wdata_i    (wdata_q),
    .be_o       (lane_be),
    .wdata_o    (lane_wdata),
    .rdata_i    (bus_rdata),
    .unsigned_i (params_q.read_unsigned),
    .rdata_o    (lane_rdata)
  );

  // Classify the incoming request: reserved size always faults, alignment optionally
  always_comb begin
    illegal_req = &mem_params.access_size;
`ifdef MEM_MISALIGN_TRAP_EN
    if ((mem_params.access_size == ACCESS_HALF) && addr[0])
      illegal_req = 1'b1;
    if ((mem_params.access_size == ACCESS_WORD) && (addr[1:0] != 2'b00))
      illegal_req = 1'b1;
`endif
  end

  // Access sequencer: IDLE -> BUS -> RESP -> IDLE with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      params_q     <= '0;
      off_q        <= 2'd0;
      wdata_q      <= 32'd0;
      tmo_q        <= 16'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= 32'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            params_q    <= mem_params;
            off_q       <= addr[1:0];
            wdata_q     <= wdata;
            req_ready_q <= 1'b0;
            if (illegal_req) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_error_q <= 1'b1;
              resp_rdata_q <= 32'd0;
            end else begin
              state_q    <= BUS;
              bus_req_q  <= 1'b1;
              bus_we_q   <= (mem_params.op == OP_WRITE);
              bus_addr_q <= {addr[31:2], 2'b00};
              tmo_q      <= 16'd0;
            end
          end
        end
        BUS: begin
          if (bus_ack) begin
            state_q      <= RESP;
            bus_req_q    <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_error_q <= 1'b0;
            resp_rdata_q <= (params_q.op == OP_READ) ? lane_rdata : 32'd0;
          end else if (tmo_d == TMO_LIMIT) begin
            state_q      <= RESP;
            bus_req_q    <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_error_q <= 1'b1;
            resp_rdata_q <= 32'd0;
          end else begin
            tmo_q <= tmo_d;
          end
        end
        RESP: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
          resp_error_q <= 1'b0;
          resp_rdata_q <= 32'd0;
          req_ready_q  <= 1'b1;
        end
        default: begin
          state_q     <= IDLE;
          bus_req_q   <= 1'b0;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_error = resp_error_q;
  assign resp_rdata = resp_rdata_q;
  assign bus_req    = bus_req_q;
  assign bus_we     = bus_we_q;
  assign bus_addr   = bus_addr_q;
  // Lane outputs come from registered operands; quiet them while no request is open
  assign bus_be     = bus_req_q ? lane_be : 4'h0;
  assign bus_wdata  = bus_req_q ? lane_wdata : 32'd0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus randomized accesses
// checked against an arithmetic byte-lane reference model.
module tb_mem_access_unit;
  import mem_pkg::*;

  localparam int TMO = 4;
`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  mem_params_t mem_params;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0]  last_be;
  logic [31:0] last_rdata;
  logic [31:0] last_wdata;
  logic [31:0] last_addr;
  logic        last_err;
  logic        last_we;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .mem_params (mem_params),
    .addr       (addr),
    .wdata      (wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_error (resp_error),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_be     (bus_be),
    .bus_wdata  (bus_wdata),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: lanes described as a byte range [lo, lo+n)
  function automatic int nbytes(input int sz);
    return (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
  endfunction

  function automatic int lane_lo(input int sz, input int a);
    if (sz == 0) return a;
    if (sz == 1) return (a / 2) * 2;
    return 0;
  endfunction

  function automatic logic [3:0] model_be(input int sz, input int a);
    logic [3:0] b = 4'h0;
    for (int i = 0; i < 4; i++)
      if (i >= lane_lo(sz, a) && i < lane_lo(sz, a) + nbytes(sz)) b[i] = 1'b1;
    return b;
  endfunction

  function automatic logic [31:0] model_wdata(input int sz, input logic [31:0] w);
    logic [31:0] r = 32'd0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(i % nbytes(sz)) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_rdata(input int sz, input int a,
                                              input logic [31:0] rd, input bit uns);
    logic [63:0] v;
    logic [63:0] mask;
    int n = nbytes(sz);
    v = {32'd0, rd} >> (8 * lane_lo(sz, a));
    mask = (64'd1 << (8 * n)) - 64'd1;
    v = v & mask;
    if (!uns && n < 4 && v[8*n-1]) v = v | ~mask;
    return v[31:0];
  endfunction

  // One complete access; ack_at = bus_req cycle in which ack is given (> TMO: never)
  task automatic do_access(input bit op, input int sz, input bit uns, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rd, input int ack_at);
    mem_params_t p;
    bit          illegal;
    bit          acked = 1'b0;
    int          cyc;
    logic [3:0]  ebe;
    logic [31:0] ewd;
    logic [31:0] erd;
    illegal = (sz == 3) || (TRAP && ((sz == 1 && a[0]) || (sz == 2 && a[1:0] != 2'b00)));
    ebe = model_be(sz, int'(a[1:0]));
    ewd = model_wdata(sz, wd);
    erd = op ? model_rdata(sz, int'(a[1:0]), rd, uns) : 32'd0;
    last_be = 4'h0; last_wdata = 32'd0; last_addr = 32'd0; last_we = 1'b0;
    @(negedge clk);
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    p.op = op;
    p.access_size = access_size_t'(sz[1:0]);
    p.read_unsigned = uns;
    mem_params = p; addr = a; wdata = wd; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("req_ready_busy", {31'd0, req_ready}, 32'd0);
    if (!illegal) begin
      cyc = 1;
      while (cyc <= TMO) begin
        check("bus_req_hi", {31'd0, bus_req}, 32'd1);
        check("bus_addr", bus_addr, {a[31:2], 2'b00});
        check("bus_we", {31'd0, bus_we}, {31'd0, ~op});
        check("bus_be", {28'd0, bus_be}, {28'd0, ebe});
        if (!op) check("bus_wdata", bus_wdata, ewd);
        check("resp_valid_in_bus", {31'd0, resp_valid}, 32'd0);
        last_be = bus_be; last_wdata = bus_wdata; last_addr = bus_addr; last_we = bus_we;
        if (cyc == ack_at) begin bus_ack = 1'b1; bus_rdata = rd; end
        else begin bus_ack = 1'b0; bus_rdata = $urandom; end
        @(negedge clk);
        bus_ack = 1'b0;
        if (cyc == ack_at) begin acked = 1'b1; break; end
        cyc++;
      end
    end
    check("bus_req_low", {31'd0, bus_req}, 32'd0);
    check("resp_valid", {31'd0, resp_valid}, 32'd1);
    check("resp_error", {31'd0, resp_error}, {31'd0, (illegal || !acked)});
    check("resp_rdata", resp_rdata, (illegal || !acked) ? 32'd0 : erd);
    last_rdata = resp_rdata; last_err = resp_error;
    @(negedge clk);
    check("resp_pulse_end", {31'd0, resp_valid}, 32'd0);
    check("req_ready_back", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int r, sz;
    reset = 1'b1; req_valid = 1'b0; mem_params = '0; addr = 32'd0; wdata = 32'd0;
    bus_ack = 1'b0; bus_rdata = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_error", {31'd0, resp_error}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_bus_req", {31'd0, bus_req}, 32'd0);
    check("rst_bus_we", {31'd0, bus_we}, 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    check("rst_bus_be", {28'd0, bus_be}, 32'd0);
    check("rst_bus_wdata", bus_wdata, 32'd0);
    reset = 1'b0;

    // Stray acks while idle must be ignored
    @(negedge clk);
    bus_ack = 1'b1; bus_rdata = $urandom;
    repeat (2) begin
      @(negedge clk);
      check("idle_ack_bus_req", {31'd0, bus_req}, 32'd0);
      check("idle_ack_resp", {31'd0, resp_valid}, 32'd0);
    end
    bus_ack = 1'b0;

    // lb, ack in first bus cycle
    do_access(1'b1, 0, 1'b0, 32'h0000_0103, $urandom, 32'h80FF_FF00, 1);
    check("t1_be", {28'd0, last_be}, 32'h8);
    check("t1_rdata", last_rdata, 32'hFFFF_FF80);

    // lhu, ack after three cycles
    do_access(1'b1, 1, 1'b1, 32'h0000_0102, $urandom, 32'hABCD_1234, 3);
    check("t2_be", {28'd0, last_be}, 32'hC);
    check("t2_rdata", last_rdata, 32'h0000_ABCD);
    check("t2_err", {31'd0, last_err}, 32'd0);

    // sb
    do_access(1'b0, 0, 1'b0, 32'h0000_0201, 32'h0000_0055, $urandom, 2);
    check("t3_we", {31'd0, last_we}, 32'd1);
    check("t3_be", {28'd0, last_be}, 32'h2);
    check("t3_wdata", last_wdata, 32'h5555_5555);
    check("t3_addr", last_addr, 32'h0000_0200);
    check("t3_rdata", last_rdata, 32'd0);

    // Timeout with no ack, then ack on the last allowed cycle
    do_access(1'b1, 2, 1'b0, 32'h0000_0300, $urandom, $urandom, TMO + 10);
    check("t4_tmo_err", {31'd0, last_err}, 32'd1);
    check("t4_tmo_rdata", last_rdata, 32'd0);
    do_access(1'b1, 2, 1'b0, 32'h0000_0304, $urandom, 32'h1234_5678, TMO);
    check("t4_lastack_err", {31'd0, last_err}, 32'd0);
    check("t4_lastack_rdata", last_rdata, 32'h1234_5678);

    // Misaligned word and reserved size
    do_access(1'b1, 2, 1'b0, 32'h0000_0102, $urandom, 32'hCAFE_F00D, 1);
    check("t5_err", {31'd0, last_err}, {31'd0, TRAP});
    check("t5_be", {28'd0, last_be}, TRAP ? 32'h0 : 32'hF);
    check("t5_addr", last_addr, TRAP ? 32'h0 : 32'h0000_0100);
    check("t5_rdata", last_rdata, TRAP ? 32'h0 : 32'hCAFE_F00D);
    do_access(1'b1, 3, 1'b0, 32'h0000_0100, $urandom, $urandom, 1);
    check("t5_rsvd_err", {31'd0, last_err}, 32'd1);
    check("t5_rsvd_be", {28'd0, last_be}, 32'h0);

    // Reset while the bus request is open
    @(negedge clk);
    mem_params.op = 1'b1; mem_params.access_size = ACCESS_WORD; mem_params.read_unsigned = 1'b0;
    addr = 32'h0000_0400; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("t6_bus_req_open", {31'd0, bus_req}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t6_bus_req_rst", {31'd0, bus_req}, 32'd0);
    check("t6_ready_rst", {31'd0, req_ready}, 32'd1);
    check("t6_resp_rst", {31'd0, resp_valid}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("t6_resp_after", {31'd0, resp_valid}, 32'd0);
    check("t6_bus_req_after", {31'd0, bus_req}, 32'd0);
    do_access(1'b1, 1, 1'b0, 32'h0000_0406, $urandom, 32'h8001_7FFF, 2);
    check("t6_followup_rdata", last_rdata, 32'hFFFF_8001);

    // Randomized accesses
    repeat (60) begin
      r = $urandom_range(0, 9);
      sz = (r < 3) ? 0 : (r < 6) ? 1 : (r < 9) ? 2 : 3;
      do_access(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), $urandom,
                $urandom, $urandom, $urandom_range(1, TMO + 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
